// File: rtl/bus_pkg.sv
// Shared definitions for the 32-bit tri-state datapath bus, used by both
// the driver side and the receiver side.
package bus_pkg;

  localparam int BUS_W    = 32;
  localparam int DEF_ID_W = 3;

  localparam logic [DEF_ID_W-1:0] RF_ID  = 3'd0;
  localparam logic [DEF_ID_W-1:0] MEM_ID = 3'd1;
  localparam logic [DEF_ID_W-1:0] ALU_ID = 3'd2;
  localparam logic [DEF_ID_W-1:0] IO_ID  = 3'd3;

  // Even parity: the parity bit makes the total number of ones even.
  function automatic logic even_parity(input logic [BUS_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/sync_fifo_core.sv
// Single-clock FIFO storage with an extra pointer MSB to tell full from empty.
// Head word is presented combinationally; reads as zero while empty.
module sync_fifo_core #(
  parameter int  DEPTH = 4,
  parameter int  W     = 32,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic [W-1:0]     wdata,
  input  logic             pop,
  output logic [W-1:0]     rdata,
  output logic             full,
  output logic             empty,
  output logic [PTR_W:0]   count
);

  logic [W-1:0]   mem [DEPTH];
  logic [PTR_W:0] wr_ptr;
  logic [PTR_W:0] rd_ptr;
  logic           do_push;
  logic           do_pop;

  assign count   = wr_ptr - rd_ptr;
  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = empty ? '0 : mem[rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage carries no reset; its contents only matter between push and pop.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[PTR_W-1:0]] <= wdata;
  end

endmodule

// File: rtl/bus_receiver_fifo.sv
// Receiver end of the shared datapath bus: tag filter, parity check, FIFO
// buffering toward the local consumer, and registered backpressure.
module bus_receiver_fifo
  import bus_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter int  ID_W  = DEF_ID_W,
  parameter int  MY_ID = 0,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [BUS_W-1:0] bus_data,
  input  logic             bus_valid,
  input  logic [ID_W-1:0]  bus_dest,
  input  logic             bus_parity,
  output logic             bus_stall,
  output logic [BUS_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             parity_err,
  input  logic             err_clear,
  output logic [PTR_W:0]   count
);

  // Consumer handshake: a word transfers on a rising edge where out_valid and
  // out_ready are both 1; out_data is stable while out_valid=1 and not popped.
  logic           full;
  logic           empty;
  logic           match;
  logic           acc;
  logic           pop;
  logic           overflow;
  logic           bad_par;
  logic           err_set;
  logic [PTR_W:0] count_next;
  logic           stall_next;

  assign match    = bus_valid & (bus_dest == ID_W'(MY_ID));
  assign acc      = match & ~full;
  assign overflow = match & full;
  assign out_valid = ~empty;
  assign pop      = out_valid & out_ready;
  assign bad_par  = (even_parity(bus_data) != bus_parity);
  assign err_set  = (acc & bad_par) | overflow;

  sync_fifo_core #(
    .DEPTH (DEPTH),
    .W     (BUS_W)
  ) u_core (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (acc),
    .wdata   (bus_data),
    .pop     (pop),
    .rdata   (out_data),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  // Stall one entry early so a driver granted as stall rises still fits.
  assign count_next = count + (PTR_W+1)'(acc) - (PTR_W+1)'(pop);
  assign stall_next = (count_next == (PTR_W+1)'(DEPTH)) |
                      ((count_next == (PTR_W+1)'(DEPTH-1)) & acc & ~pop);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bus_stall  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      bus_stall <= stall_next;
      if (err_set)        parity_err <= 1'b1;
      else if (err_clear) parity_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bus_receiver_fifo.sv
// Self-checking bench for bus_receiver_fifo with a queue-based reference model.
module tb_bus_receiver_fifo;

  localparam int DEPTH = 4;
  localparam int ID_W  = 3;
  localparam int MY_ID = 0;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] bus_data;
  logic        bus_valid;
  logic [2:0]  bus_dest;
  logic        bus_parity;
  logic        bus_stall;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        parity_err;
  logic        err_clear;
  logic [2:0]  count;

  logic [31:0] exp_q[$];
  logic        m_err;
  logic        m_stall;
  int          n_vec;
  int          n_err;

  bus_receiver_fifo #(
    .DEPTH (DEPTH),
    .ID_W  (ID_W),
    .MY_ID (MY_ID)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .bus_data   (bus_data),
    .bus_valid  (bus_valid),
    .bus_dest   (bus_dest),
    .bus_parity (bus_parity),
    .bus_stall  (bus_stall),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .parity_err (parity_err),
    .err_clear  (err_clear),
    .count      (count)
  );

  // Clock and watchdog
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] d, input logic [31:0] data,
                       input logic bad_par, input logic rdy, input logic clr);
    bus_valid  = v;
    bus_dest   = d;
    bus_data   = data;
    bus_parity = (^data) ^ bad_par;
    out_ready  = rdy;
    err_clear  = clr;
  endtask

  task automatic idle(input logic rdy, input logic clr);
    drive(1'b0, 3'd0, 32'hxxxx_xxxx, 1'b0, rdy, clr);
  endtask

  // One clock: model the edge from the inputs in place, then compare after it.
  task automatic step();
    bit full, pop, acc, set;
    int cnt_next;
    @(negedge clock);
    full = (exp_q.size() == DEPTH);
    pop  = (exp_q.size() != 0) && out_ready;
    acc  = bus_valid && (bus_dest == MY_ID) && !full;
    if (pop) check("pop_data", out_data, exp_q.pop_front());
    set = (acc && ((^bus_data) != bus_parity)) || (bus_valid && (bus_dest == MY_ID) && full);
    if (acc) exp_q.push_back(bus_data);
    cnt_next = exp_q.size();
    m_stall  = (cnt_next == DEPTH) || ((cnt_next == DEPTH - 1) && acc && !pop);
    m_err    = set ? 1'b1 : (err_clear ? 1'b0 : m_err);
    @(posedge clock);
    #1;
    check("count", 32'(count), cnt_next);
    check("out_valid", 32'(out_valid), 32'(cnt_next != 0));
    check("bus_stall", 32'(bus_stall), 32'(m_stall));
    check("parity_err", 32'(parity_err), 32'(m_err));
  endtask

  task automatic drain();
    idle(1'b1, 1'b0);
    for (int i = 0; i < DEPTH + 2 && exp_q.size() != 0; i++) step();
    check("drained", 32'(out_valid), 32'd0);
  endtask

  task automatic clear_err();
    idle(1'b0, 1'b1);
    step();
  endtask

  initial begin
    n_vec   = 0;
    n_err   = 0;
    m_err   = 1'b0;
    m_stall = 1'b0;
    reset_n = 1'b0;
    idle(1'b0, 1'b0);
    repeat (2) @(posedge clock);
    #1;
    check("rst_count", 32'(count), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_stall", 32'(bus_stall), 32'd0);
    check("rst_data", out_data, 32'd0);
    check("rst_perr", 32'(parity_err), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    // 1: two writes, asynchronous reset mid-cycle, then first word after release
    drive(1'b1, 3'(MY_ID), 32'h1111_0001, 1'b0, 1'b0, 1'b0); step();
    drive(1'b1, 3'(MY_ID), 32'h1111_0002, 1'b0, 1'b0, 1'b0); step();
    idle(1'b0, 1'b0);
    #3;
    reset_n = 1'b0;
    #1;
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_stall", 32'(bus_stall), 32'd0);
    check("mid_rst_data", out_data, 32'd0);
    exp_q.delete();
    m_err   = 1'b0;
    m_stall = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    drive(1'b1, 3'(MY_ID), 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0); step();
    check("first_valid", 32'(out_valid), 32'd1);
    check("first_data", out_data, 32'hDEAD_BEEF);
    drain();

    // 2: tag filter
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 3'(i), 32'hBAD0_0000 + 32'(i), 1'b1, 1'b0, 1'b0);
      step();
    end
    drive(1'b1, 3'(MY_ID), 32'h1234_5678, 1'b0, 1'b0, 1'b0); step();
    check("tag_count", 32'(count), 32'd1);
    check("tag_data", out_data, 32'h1234_5678);
    check("tag_perr", 32'(parity_err), 32'd0);
    drain();

    // 3: fill, stall, overflow, drain, wrap
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 3'(MY_ID), 32'hA0 + 32'(i), 1'b0, 1'b0, 1'b0);
      step();
      if (i == 1) check("stall_after_2nd", 32'(bus_stall), 32'd0);
      if (i == 2) check("stall_after_3rd", 32'(bus_stall), 32'd1);
    end
    check("full_count", 32'(count), 32'd4);
    drive(1'b1, 3'(MY_ID), 32'hA4, 1'b0, 1'b0, 1'b0); step();
    check("ovf_count", 32'(count), 32'd4);
    check("ovf_perr", 32'(parity_err), 32'd1);
    check("ovf_head", out_data, 32'hA0);
    drain();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 3'(MY_ID), 32'hB0 + 32'(i), 1'b0, 1'b1, 1'b0);
      step();
    end
    drain();
    clear_err();

    // 4: simultaneous push/pop at count=2
    drive(1'b1, 3'(MY_ID), 32'hC000_0000, 1'b0, 1'b0, 1'b0); step();
    drive(1'b1, 3'(MY_ID), 32'hC000_0001, 1'b0, 1'b0, 1'b0); step();
    for (int i = 2; i < 12; i++) begin
      drive(1'b1, 3'(MY_ID), 32'hC000_0000 + 32'(i), 1'b0, 1'b1, 1'b0);
      step();
      check("pp_count", 32'(count), 32'd2);
      check("pp_stall", 32'(bus_stall), 32'd0);
    end
    drain();

    // 5: parity error, clear, clear colliding with a new bad word
    drive(1'b1, 3'(MY_ID), 32'h0000_0001, 1'b1, 1'b0, 1'b0); step();
    check("par_perr", 32'(parity_err), 32'd1);
    check("par_stored", out_data, 32'h0000_0001);
    idle(1'b0, 1'b1); step();
    check("par_clear", 32'(parity_err), 32'd0);
    drive(1'b1, 3'(MY_ID), 32'h0000_0003, 1'b1, 1'b0, 1'b1); step();
    check("par_set_wins", 32'(parity_err), 32'd1);
    drain();
    clear_err();

    // Random traffic
    for (int i = 0; i < 80; i++) begin
      drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 3)), $urandom,
            1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 3) == 0));
      step();
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
